// File: rtl/vram_write_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_write_queue_if: CPU write port / controller read port of queue  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface vram_write_queue_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int INDEX_WIDTH   = 3
);
  logic                     flush;
  logic                     clear_errors;
  logic                     write_request;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     read_request;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [INDEX_WIDTH:0]     items_count;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic                     overrun;
  logic                     underrun;

  modport master (
    output flush, clear_errors, write_request, write_address, write_data, read_request,
    input  read_address, read_data, items_count, full, empty,
           almost_full, almost_empty, overrun, underrun
  );

  modport slave (
    input  flush, clear_errors, write_request, write_address, write_data, read_request,
    output read_address, read_data, items_count, full, empty,
           almost_full, almost_empty, overrun, underrun
  );
endinterface
`default_nettype wire

// File: rtl/vram_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_write_queue: FWFT {address,data} VRAM write buffer with flags,  |
// | flush, sticky errors and optional same-address coalescing. Rev 1.0   |
// +----------------------------------------------------------------------+
module vram_write_queue #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESS_WIDTH      = 16,
  parameter int INDEX_WIDTH        = 3,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  parameter int COALESCE           = 1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  vram_write_queue_if.slave bus
);
  localparam int                     c_depth        = 1 << INDEX_WIDTH;
  localparam logic [INDEX_WIDTH:0]   c_depth_count  = (INDEX_WIDTH+1)'(c_depth);
  localparam logic [INDEX_WIDTH:0]   c_cnt_one      = (INDEX_WIDTH+1)'(1);
  localparam logic [INDEX_WIDTH-1:0] c_idx_one      = INDEX_WIDTH'(1);
  localparam logic [INDEX_WIDTH:0]   c_af_level     = (INDEX_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [INDEX_WIDTH:0]   c_ae_level     = (INDEX_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

  logic [ADDRESS_WIDTH-1:0] r_addr_mem [c_depth];
  logic [DATA_WIDTH-1:0]    r_data_mem [c_depth];

  logic [INDEX_WIDTH:0]     r_wr_ptr;
  logic [INDEX_WIDTH:0]     r_rd_ptr;
  logic [INDEX_WIDTH:0]     r_count;
  logic                     r_overrun;
  logic                     r_underrun;

  logic [INDEX_WIDTH-1:0]   w_wr_idx;
  logic [INDEX_WIDTH-1:0]   w_rd_idx;
  logic [INDEX_WIDTH-1:0]   w_newest_idx;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_coalesce;
  logic                     w_read_ok;
  logic                     w_write_ok;
  logic                     w_overrun_evt;
  logic                     w_underrun_evt;
  logic [INDEX_WIDTH:0]     w_count_next;

  assign w_wr_idx     = r_wr_ptr[INDEX_WIDTH-1:0];
  assign w_rd_idx     = r_rd_ptr[INDEX_WIDTH-1:0];
  assign w_newest_idx = w_wr_idx - c_idx_one;
  assign w_full       = (r_count == c_depth_count);
  assign w_empty      = (r_count == '0);

  // A read that would pop the only entry must not absorb a write into it,
  // otherwise the new data would leave with the popped entry.
  generate
    if (COALESCE != 0) begin : g_coalesce
      assign w_coalesce = bus.write_request && !w_empty
                          && (r_addr_mem[w_newest_idx] == bus.write_address)
                          && !(bus.read_request && (r_count == c_cnt_one));
    end else begin : g_no_coalesce
      assign w_coalesce = 1'b0;
    end
  endgenerate

  assign w_read_ok      = bus.read_request && !w_empty;
  assign w_write_ok     = bus.write_request && !w_coalesce && (!w_full || bus.read_request);
  assign w_overrun_evt  = bus.write_request && !w_coalesce && !w_write_ok;
  assign w_underrun_evt = bus.read_request && w_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_write_ok && !w_read_ok) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_write_ok && w_read_ok) begin
      w_count_next = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write_ok) begin
        r_wr_ptr <= r_wr_ptr + c_cnt_one;
      end
      if (w_read_ok) begin
        r_rd_ptr <= r_rd_ptr + c_cnt_one;
      end
      r_count    <= w_count_next;
      // A new error in the clearing cycle keeps the flag set.
      r_overrun  <= w_overrun_evt  || (r_overrun  && !bus.clear_errors);
      r_underrun <= w_underrun_evt || (r_underrun && !bus.clear_errors);
    end
  end

  // Storage is not reset; only the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush) begin
      if (w_write_ok) begin
        r_addr_mem[w_wr_idx] <= bus.write_address;
        r_data_mem[w_wr_idx] <= bus.write_data;
      end else if (w_coalesce) begin
        r_data_mem[w_newest_idx] <= bus.write_data;
      end
    end
  end

  assign bus.read_address = r_addr_mem[w_rd_idx];
  assign bus.read_data    = r_data_mem[w_rd_idx];
  assign bus.items_count  = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_af_level);
  assign bus.almost_empty = (r_count <= c_ae_level);
  assign bus.overrun      = r_overrun;
  assign bus.underrun     = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_vram_write_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vram_write_queue: table-driven bench with data scoreboard         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vram_write_queue;
  localparam int c_depth = 8;

  typedef struct {
    logic        fl;
    logic        cl;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        rd;
    int          cnt;
    logic        ov;
    logic        un;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  ent_t sb[$];

  always #5 clk = ~clk;

  vram_write_queue_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .INDEX_WIDTH(3)) bus0 ();
  vram_write_queue_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .INDEX_WIDTH(3)) bus1 ();

  vram_write_queue #(.COALESCE(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  vram_write_queue #(.COALESCE(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic fl, input logic cl, input logic wr,
                              input logic [15:0] addr, input logic [15:0] data,
                              input logic rd, input int cnt, input logic ov, input logic un);
    vec_t v;
    v.fl = fl; v.cl = cl; v.wr = wr; v.addr = addr; v.data = data;
    v.rd = rd; v.cnt = cnt; v.ov = ov; v.un = un;
    vecs.push_back(v);
  endfunction

  task automatic check_state(input string tag, input int cnt, input logic ov, input logic un);
    chk({tag, " count"},        32'(bus0.items_count), cnt);
    chk({tag, " full"},         32'(bus0.full),         32'(cnt == c_depth));
    chk({tag, " empty"},        32'(bus0.empty),        32'(cnt == 0));
    chk({tag, " almost_full"},  32'(bus0.almost_full),  32'(cnt >= 6));
    chk({tag, " almost_empty"}, 32'(bus0.almost_empty), 32'(cnt <= 1));
    chk({tag, " overrun"},      32'(bus0.overrun),      32'(ov));
    chk({tag, " underrun"},     32'(bus0.underrun),     32'(un));
    if (sb.size() > 0) begin
      chk({tag, " head_addr"}, 32'(bus0.read_address), 32'(sb[0].addr));
      chk({tag, " head_data"}, 32'(bus0.read_data),    32'(sb[0].data));
    end
  endtask

  task automatic idle0();
    bus0.flush = 1'b0; bus0.clear_errors = 1'b0; bus0.write_request = 1'b0;
    bus0.read_request = 1'b0; bus0.write_address = '0; bus0.write_data = '0;
  endtask

  // Drive one vector, update the scoreboard, then check after the edge.
  task automatic step(input string tag, input vec_t v);
    int   n;
    bit   coal;
    ent_t e;
    n = sb.size();
    if (v.rd && n > 0) begin
      chk({tag, " pop_addr"}, 32'(bus0.read_address), 32'(sb[0].addr));
      chk({tag, " pop_data"}, 32'(bus0.read_data),    32'(sb[0].data));
    end
    bus0.flush = v.fl; bus0.clear_errors = v.cl; bus0.write_request = v.wr;
    bus0.write_address = v.addr; bus0.write_data = v.data; bus0.read_request = v.rd;
    if (v.fl) begin
      sb.delete();
    end else begin
      coal = v.wr && n >= 1 && sb[n-1].addr == v.addr && !(v.rd && n == 1);
      if (coal) sb[n-1].data = v.data;
      if (v.rd && n > 0) e = sb.pop_front();
      if (v.wr && !coal && (n < c_depth || v.rd)) begin
        e.addr = v.addr; e.data = v.data;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    idle0();
    check_state(tag, v.cnt, v.ov, v.un);
  endtask

  initial begin
    idle0();
    bus1.flush = 1'b0; bus1.clear_errors = 1'b0; bus1.write_request = 1'b0;
    bus1.read_request = 1'b0; bus1.write_address = '0; bus1.write_data = '0;

    // Fill, overrun, drain, underrun, clear.
    for (int i = 0; i < 8; i++) add(0, 0, 1, 16'h4000 + 16'(i), 16'h0001 + 16'(i), 0, i + 1, 0, 0);
    add(0, 0, 1, 16'h5000, 16'h9999, 0, 8, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 16'h0, 16'h0, 1, 7 - i, 1, 0);
    add(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 1);
    add(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
    // Coalescing, then the pop-the-only-entry case.
    add(0, 0, 1, 16'h4000, 16'h1111, 0, 1, 0, 0);
    add(0, 0, 1, 16'h4000, 16'h2222, 0, 1, 0, 0);
    add(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0);
    add(0, 0, 1, 16'h4000, 16'h1111, 0, 1, 0, 0);
    add(0, 0, 1, 16'h4000, 16'h2222, 1, 1, 0, 0);
    add(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 0);
    // Read+write on empty queue.
    add(0, 0, 1, 16'h4010, 16'hABCD, 1, 1, 0, 1);
    add(0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 1);
    add(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0);
    // Wrap with 20 push/pop pairs at depth 3.
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h4300 + 16'(i), 16'hA000 + 16'(i), 0, i + 1, 0, 0);
    for (int i = 3; i < 23; i++) add(0, 0, 1, 16'h4300 + 16'(i), 16'hA000 + 16'(i), 1, 3, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0, 16'h0, 1, 2 - i, 0, 0);
    // Full queue: read+write succeeds, then a plain write overruns.
    for (int i = 0; i < 8; i++) add(0, 0, 1, 16'h4100 + 16'(i), 16'h0100 + 16'(i), 0, i + 1, 0, 0);
    add(0, 0, 1, 16'h6000, 16'h6000, 1, 8, 0, 0);
    add(0, 0, 1, 16'h7000, 16'h7000, 0, 8, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 16'h0, 16'h0, 1, 7 - i, 1, 0);
    // Flush with write+read at count 5, then clear racing a new underrun.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 16'h4200 + 16'(i), 16'h0200 + 16'(i), 0, i + 1, 1, 0);
    add(1, 0, 1, 16'h5555, 16'h5555, 1, 0, 1, 0);
    add(0, 1, 0, 16'h0, 16'h0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 16'h4400 + 16'(i), 16'h0400 + 16'(i), 0, i + 1, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_state("reset", 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step($sformatf("v%0d", i), vecs[i]);

    // Reset mid-stream with a write pending: everything discarded, write ignored.
    reset = 1'b1;
    bus0.write_request = 1'b1; bus0.write_address = 16'h4777; bus0.write_data = 16'h7777;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle0();
    sb.delete();
    check_state("midreset", 0, 0, 0);

    // Non-coalescing instance keeps both same-address writes.
    bus1.write_request = 1'b1; bus1.write_address = 16'h4000; bus1.write_data = 16'h1111;
    @(posedge clk); #1;
    bus1.write_data = 16'h2222;
    @(posedge clk); #1;
    bus1.write_request = 1'b0;
    chk("nc count2", 32'(bus1.items_count), 2);
    chk("nc head1_addr", 32'(bus1.read_address), 32'h4000);
    chk("nc head1_data", 32'(bus1.read_data), 32'h1111);
    bus1.read_request = 1'b1;
    @(posedge clk); #1;
    chk("nc count1", 32'(bus1.items_count), 1);
    chk("nc head2_data", 32'(bus1.read_data), 32'h2222);
    @(posedge clk); #1;
    bus1.read_request = 1'b0;
    chk("nc count0", 32'(bus1.items_count), 0);
    chk("nc underrun", 32'(bus1.underrun), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
